// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, active video, scaled coordinates, line/frame pulses.
// Optional VGA_TIMING_LEAD_EN delays syncs/active by LEAD enabled cycles so coordinates lead video.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit H_POL       = 1'b0,
  parameter bit V_POL       = 1'b0,
  parameter int SCALE_SHIFT = 2,
  parameter int XW          = 8,
  parameter int YW          = 8,
  parameter int LEAD        = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_en,
  output logic          o_hSync,
  output logic          o_vSync,
  output logic          o_active,
  output logic [XW-1:0] o_pxlX,
  output logic [YW-1:0] o_pxlY,
  output logic          o_lineStart,
  output logic          o_frameStart,
  output logic [7:0]    o_frameCnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_E  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_E  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_timing
    $error("vga_timing_gen: every timing parameter must be >= 1");
  end
  if (((H_ACTIVE - 1) >> SCALE_SHIFT) >= (1 << XW) ||
      ((V_ACTIVE - 1) >> SCALE_SHIFT) >= (1 << YW)) begin : g_err_coord
    $error("vga_timing_gen: scaled coordinates do not fit XW/YW");
  end
  if (LEAD < 1 || LEAD > 4) begin : g_err_lead
    $error("vga_timing_gen: LEAD must be in 1..4");
  end

  logic [HW-1:0] h_q, h_d, h_n;
  logic [VW-1:0] v_q, v_d, v_n;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic [XW-1:0] pxl_x_q, pxl_x_d;
  logic [YW-1:0] pxl_y_q, pxl_y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  // Next raster position; outputs decode this so they line up with the counter state.
  always_comb begin
    h_n = h_q + HW'(1);
    v_n = v_q;
    if (h_q == H_LAST) begin
      h_n = '0;
      v_n = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
  end

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    pxl_x_d       = pxl_x_q;
    pxl_y_d       = pxl_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (i_en) begin
      h_d           = h_n;
      v_d           = v_n;
      hsync_d       = (h_n >= HS_BEG && h_n < HS_END) ? H_POL : ~H_POL;
      vsync_d       = (v_n >= VS_BEG && v_n < VS_END) ? V_POL : ~V_POL;
      active_d      = (h_n < H_ACT_E) && (v_n < V_ACT_E);
      pxl_x_d       = (h_n < H_ACT_E) ? XW'(h_n >> SCALE_SHIFT) : '0;
      pxl_y_d       = (v_n < V_ACT_E) ? YW'(v_n >> SCALE_SHIFT) : '0;
      line_start_d  = (h_n == '0);
      frame_start_d = (h_n == '0) && (v_n == '0);
      if (frame_start_d) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      active_q      <= 1'b0;
      pxl_x_q       <= '0;
      pxl_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pxl_x_q       <= pxl_x_d;
      pxl_y_q       <= pxl_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign o_pxlX       = pxl_x_q;
  assign o_pxlY       = pxl_y_q;
  assign o_lineStart  = line_start_q;
  assign o_frameStart = frame_start_q;
  assign o_frameCnt   = frame_cnt_q;

`ifdef VGA_TIMING_LEAD_EN
  // Video-side delay line; coordinates stay early to cover memory read latency.
  logic [LEAD-1:0] lead_hs_q, lead_hs_d;
  logic [LEAD-1:0] lead_vs_q, lead_vs_d;
  logic [LEAD-1:0] lead_act_q, lead_act_d;

  always_comb begin
    lead_hs_d  = lead_hs_q;
    lead_vs_d  = lead_vs_q;
    lead_act_d = lead_act_q;
    if (i_en) begin
      lead_hs_d  = LEAD'({lead_hs_q, hsync_q});
      lead_vs_d  = LEAD'({lead_vs_q, vsync_q});
      lead_act_d = LEAD'({lead_act_q, active_q});
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lead_hs_q  <= {LEAD{~H_POL}};
      lead_vs_q  <= {LEAD{~V_POL}};
      lead_act_q <= '0;
    end else begin
      lead_hs_q  <= lead_hs_d;
      lead_vs_q  <= lead_vs_d;
      lead_act_q <= lead_act_d;
    end
  end

  assign o_hSync  = lead_hs_q[LEAD-1];
  assign o_vSync  = lead_vs_q[LEAD-1];
  assign o_active = lead_act_q[LEAD-1];
`else
  assign o_hSync  = hsync_q;
  assign o_vSync  = vsync_q;
  assign o_active = active_q;
`endif

endmodule
